// File: rtl/dcache_flush_unit_pkg.sv
// Shared types and D$ geometry defaults for the D$ flush responder.
package dcache_flush_unit_pkg;

  localparam int unsigned DCACHE_NR_SETS      = 256;
  localparam int unsigned DCACHE_NR_WAYS      = 8;
  localparam int unsigned DCACHE_TAG_WIDTH    = 44;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WB_REQ,
    WB_WAIT,
    INVAL,
    ACK
  } flush_state_e;

  // A single-way cache still needs a one-bit way select.
  function automatic int unsigned way_width(input int unsigned nr_ways);
    return (nr_ways > 1) ? $clog2(nr_ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_flush_unit_if.sv
// Flush request/ack, tag-array and write-back signals seen by the D$ flush responder.
interface dcache_flush_if
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned NR_SETS      = DCACHE_NR_SETS,
  parameter int unsigned NR_WAYS      = DCACHE_NR_WAYS,
  parameter int unsigned TAG_WIDTH    = DCACHE_TAG_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DCACHE_OFFSET_WIDTH
) ();

  localparam int unsigned IDX_W   = $clog2(NR_SETS);
  localparam int unsigned WAY_W   = way_width(NR_WAYS);
  localparam int unsigned PADDR_W = TAG_WIDTH + IDX_W + OFFSET_WIDTH;

  logic                           flush_i;
  logic                           flush_ack_o;
  logic                           flush_busy_o;
  logic                           miss_busy_i;
  logic                           tag_req_o;
  logic                           tag_gnt_i;
  logic                           tag_we_o;
  logic [IDX_W-1:0]               tag_index_o;
  logic [NR_WAYS*TAG_WIDTH-1:0]   tag_rdata_i;
  logic [NR_WAYS-1:0]             valid_i;
  logic [NR_WAYS-1:0]             dirty_i;
  logic                           wb_req_o;
  logic                           wb_gnt_i;
  logic [PADDR_W-1:0]             wb_addr_o;
  logic [WAY_W-1:0]               wb_way_o;
  logic                           wb_done_i;

  modport slave (
    input  flush_i, miss_busy_i, tag_gnt_i, tag_rdata_i, valid_i, dirty_i,
           wb_gnt_i, wb_done_i,
    output flush_ack_o, flush_busy_o, tag_req_o, tag_we_o, tag_index_o,
           wb_req_o, wb_addr_o, wb_way_o
  );

  modport master (
    output flush_i, miss_busy_i, tag_gnt_i, tag_rdata_i, valid_i, dirty_i,
           wb_gnt_i, wb_done_i,
    input  flush_ack_o, flush_busy_o, tag_req_o, tag_we_o, tag_index_o,
           wb_req_o, wb_addr_o, wb_way_o
  );

endinterface

// File: rtl/dcache_flush_unit_dirty_way_sel.sv
// Picks the lowest-numbered way whose bit is set in a per-way mask.
module dirty_way_sel #(
  parameter int unsigned NR_WAYS = 8,
  parameter int unsigned WAY_W   = 3
) (
  input  logic [NR_WAYS-1:0] mask_i,
  output logic [WAY_W-1:0]   idx_o,
  output logic               any_o
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    for (int i = NR_WAYS - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = WAY_W'(i);
    end
  end

endmodule

// File: rtl/dcache_flush_unit.sv
// D$ flush responder: walks every set, writes back dirty lines, invalidates the set, then acks.
module dcache_flush_unit
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned NR_SETS      = DCACHE_NR_SETS,
  parameter int unsigned NR_WAYS      = DCACHE_NR_WAYS,
  parameter int unsigned TAG_WIDTH    = DCACHE_TAG_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DCACHE_OFFSET_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dcache_flush_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NR_SETS);
  localparam int unsigned WAY_W = way_width(NR_WAYS);

  flush_state_e                 state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NR_WAYS-1:0]           mask_q, mask_d;
  logic [NR_WAYS*TAG_WIDTH-1:0] tags_q;

  logic [NR_WAYS-1:0]           sel_mask;
  logic [NR_WAYS-1:0]           way_bit;
  logic [WAY_W-1:0]             sel_way;
  logic                         sel_any;
  logic [TAG_WIDTH-1:0]         sel_tag;
  logic                         tag_req, tag_we, wb_req, ack, wb_active;

  // In CHECK the fresh read data decides; afterwards the latched copy drives the write-backs.
  assign sel_mask = (state_q == CHECK) ? (bus.valid_i & bus.dirty_i) : mask_q;

  dirty_way_sel #(
    .NR_WAYS (NR_WAYS),
    .WAY_W   (WAY_W)
  ) u_dirty_way_sel (
    .mask_i (sel_mask),
    .idx_o  (sel_way),
    .any_o  (sel_any)
  );

  assign way_bit = NR_WAYS'(1) << sel_way;
  assign sel_tag = tags_q[sel_way*TAG_WIDTH +: TAG_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

  // Tag copy is plain data; it is only looked at while the mask says a line is pending.
  always_ff @(posedge clk_i) begin
    if (state_q == CHECK) tags_q <= bus.tag_rdata_i;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    tag_req = 1'b0;
    tag_we  = 1'b0;
    wb_req  = 1'b0;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_i && !bus.miss_busy_i) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        tag_req = 1'b1;
        if (bus.tag_gnt_i) state_d = CHECK;
      end
      CHECK: begin
        mask_d  = sel_mask;
        state_d = sel_any ? WB_REQ : INVAL;
      end
      WB_REQ: begin
        wb_req = 1'b1;
        if (bus.wb_gnt_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (bus.wb_done_i) begin
          mask_d  = mask_q & ~way_bit;
          state_d = (|(mask_q & ~way_bit)) ? WB_REQ : INVAL;
        end
      end
      INVAL: begin
        tag_req = 1'b1;
        tag_we  = 1'b1;
        if (bus.tag_gnt_i) begin
          if (idx_q == IDX_W'(NR_SETS - 1)) begin
            state_d = ACK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end
      ACK: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_active        = (state_q == WB_REQ) || (state_q == WB_WAIT);
  assign bus.flush_ack_o  = ack;
  assign bus.flush_busy_o = (state_q != IDLE);
  assign bus.tag_req_o    = tag_req;
  assign bus.tag_we_o     = tag_we;
  assign bus.tag_index_o  = tag_req ? idx_q : '0;
  assign bus.wb_req_o     = wb_req;
  assign bus.wb_way_o     = wb_active ? sel_way : '0;
  assign bus.wb_addr_o    = wb_active ? {sel_tag, idx_q, OFFSET_WIDTH'(0)} : '0;

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Directed bench for dcache_flush_unit with a 4-set cache, tag-array model and write-back responder.
module tb_dcache_flush_unit;

  localparam int NS = 4;
  localparam int NW = 8;
  localparam int TW = 44;
  localparam int PW = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache_flush_if #(.NR_SETS(NS), .NR_WAYS(NW), .TAG_WIDTH(TW), .OFFSET_WIDTH(4)) bus ();

  dcache_flush_unit #(.NR_SETS(NS), .NR_WAYS(NW), .TAG_WIDTH(TW), .OFFSET_WIDTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] tags_m [NS][NW];
  logic [NW-1:0] valid_m [NS];
  logic [NW-1:0] dirty_m [NS];
  int            rd_log[$];
  int            inv_log[$];
  logic [PW-1:0] wb_addr_log[$];
  int            wb_way_log[$];

  int            wb_gnt_wait = 0;
  int            wb_done_dly = 1;
  bit            pend = 0;
  int            last_gwait = 0;
  logic [PW-1:0] cap_addr;
  logic [2:0]    cap_way;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic init_mem();
    for (int s = 0; s < NS; s++) begin
      valid_m[s] = '0;
      dirty_m[s] = '0;
      for (int w = 0; w < NW; w++) tags_m[s][w] = '0;
    end
    rd_log.delete();
    inv_log.delete();
    wb_addr_log.delete();
    wb_way_log.delete();
  endtask

  // Raise flush, wait for ack, drop flush one cycle later, then watch for stray acks.
  task automatic run_flush(output int cycles, output int acks);
    bit got;
    got    = 0;
    cycles = 0;
    acks   = 0;
    bus.flush_i = 1'b1;
    while (!got && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (bus.flush_ack_o) begin
        got = 1;
        acks++;
      end
    end
    check("ack_seen", 64'(got), 64'd1);
    @(negedge clk);
    if (bus.flush_ack_o) acks++;
    bus.flush_i = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.flush_ack_o) acks++;
    end
  endtask

  // Tag array: read data appears the cycle after a granted read; granted writes invalidate.
  initial begin
    int s;
    bus.tag_rdata_i = '0;
    bus.valid_i     = '0;
    bus.dirty_i     = '0;
    forever begin
      @(negedge clk);
      if (bus.tag_req_o && bus.tag_gnt_i) begin
        s = int'(bus.tag_index_o);
        if (!bus.tag_we_o) begin
          for (int w = 0; w < NW; w++) bus.tag_rdata_i[w*TW +: TW] = tags_m[s][w];
          bus.valid_i = valid_m[s];
          bus.dirty_i = dirty_m[s];
          rd_log.push_back(s);
        end else begin
          valid_m[s] = '0;
          dirty_m[s] = '0;
          inv_log.push_back(s);
        end
      end
    end
  end

  // Write-back port: optional grant stall, done pulse wb_done_dly cycles after grant.
  initial begin
    int gw;
    int dc;
    gw = 0;
    dc = 0;
    bus.wb_gnt_i  = 1'b0;
    bus.wb_done_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.wb_gnt_i  = 1'b0;
      bus.wb_done_i = 1'b0;
      if (rst) begin
        pend = 0;
        gw   = 0;
      end else if (pend) begin
        if (dc <= 0) begin
          bus.wb_done_i = 1'b1;
          pend = 0;
        end else begin
          dc--;
        end
      end else if (bus.wb_req_o) begin
        if (gw == 0) begin
          cap_addr = bus.wb_addr_o;
          cap_way  = bus.wb_way_o;
        end else begin
          check("wb_addr_stable", 64'(bus.wb_addr_o), 64'(cap_addr));
          check("wb_way_stable", 64'(bus.wb_way_o), 64'(cap_way));
        end
        if (gw >= wb_gnt_wait) begin
          bus.wb_gnt_i = 1'b1;
          pend       = 1;
          dc         = wb_done_dly - 1;
          last_gwait = gw;
          gw         = 0;
          wb_addr_log.push_back(bus.wb_addr_o);
          wb_way_log.push_back(int'(bus.wb_way_o));
        end else begin
          gw++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    int  acks;
    bit  found;
    bus.flush_i     = 1'b0;
    bus.miss_busy_i = 1'b0;
    bus.tag_gnt_i   = 1'b1;
    init_mem();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({bus.flush_ack_o, bus.flush_busy_o, bus.tag_req_o, bus.tag_we_o, bus.wb_req_o}), 64'd0);
    check("rst_index", 64'(bus.tag_index_o), 64'd0);
    check("rst_wb_addr", 64'(bus.wb_addr_o), 64'd0);
    check("rst_wb_way", 64'(bus.wb_way_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: clean cache
    init_mem();
    run_flush(cyc, acks);
    check("t1_latency", 64'(cyc), 64'd13);
    check("t1_acks", 64'(acks), 64'd1);
    check("t1_reads", 64'(rd_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t1_read_idx", 64'(rd_log[i]), 64'(i));
    check("t1_invals", 64'(inv_log.size()), 64'd4);
    check("t1_no_wb", 64'(wb_addr_log.size()), 64'd0);
    check("t1_idle", 64'(bus.flush_busy_o), 64'd0);

    // 2: set 2 with dirty ways 1 and 5, clean way 3
    init_mem();
    tags_m[2][1] = 44'h123;
    tags_m[2][3] = 44'h333;
    tags_m[2][5] = 44'h456;
    valid_m[2]   = 8'b0010_1010;
    dirty_m[2]   = 8'b0010_0010;
    run_flush(cyc, acks);
    check("t2_acks", 64'(acks), 64'd1);
    check("t2_wb_count", 64'(wb_addr_log.size()), 64'd2);
    check("t2_wb0_way", 64'(wb_way_log[0]), 64'd1);
    check("t2_wb0_addr", 64'(wb_addr_log[0]), 64'h48E0);
    check("t2_wb1_way", 64'(wb_way_log[1]), 64'd5);
    check("t2_wb1_addr", 64'(wb_addr_log[1]), 64'h115A0);
    check("t2_set2_valid", 64'(valid_m[2]), 64'd0);
    check("t2_set2_dirty", 64'(dirty_m[2]), 64'd0);
    check("t2_invals", 64'(inv_log.size()), 64'd4);

    // 3: write-back grant held off for 5 cycles
    init_mem();
    tags_m[0][2] = 44'hABC;
    valid_m[0]   = 8'b0000_0100;
    dirty_m[0]   = 8'b0000_0100;
    wb_gnt_wait  = 5;
    run_flush(cyc, acks);
    wb_gnt_wait  = 0;
    check("t3_acks", 64'(acks), 64'd1);
    check("t3_gnt_wait", 64'(last_gwait), 64'd5);
    check("t3_wb_way", 64'(wb_way_log[0]), 64'd2);
    check("t3_wb_addr", 64'(wb_addr_log[0]), 64'h2AF00);

    // 4: miss unit busy blocks the start
    init_mem();
    bus.miss_busy_i = 1'b1;
    bus.flush_i     = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t4_busy_low", 64'(bus.flush_busy_o), 64'd0);
      check("t4_no_tag_req", 64'(bus.tag_req_o), 64'd0);
    end
    bus.miss_busy_i = 1'b0;
    run_flush(cyc, acks);
    check("t4_latency", 64'(cyc), 64'd13);
    check("t4_first_idx", 64'(rd_log[0]), 64'd0);

    // 5: reset during the write-back wait of set 1
    init_mem();
    tags_m[1][0] = 44'h7;
    valid_m[1]   = 8'b0000_0001;
    dirty_m[1]   = 8'b0000_0001;
    wb_done_dly  = 30;
    bus.flush_i  = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (pend && !bus.wb_req_o) found = 1;
    end
    check("t5_reached_wb_wait", 64'(found), 64'd1);
    check("t5_wb_addr", 64'(bus.wb_addr_o), 64'h1D0);
    #2;
    rst = 1'b1;
    bus.flush_i = 1'b0;
    #1;
    check("t5_rst_ctrl", 64'({bus.flush_ack_o, bus.flush_busy_o, bus.tag_req_o, bus.tag_we_o, bus.wb_req_o}), 64'd0);
    check("t5_rst_wb_addr", 64'(bus.wb_addr_o), 64'd0);
    check("t5_rst_wb_way", 64'(bus.wb_way_o), 64'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.flush_ack_o) acks++;
    end
    check("t5_no_ack_in_rst", 64'(acks), 64'd0);
    rst = 1'b0;
    wb_done_dly = 1;
    rd_log.delete();
    inv_log.delete();
    wb_addr_log.delete();
    wb_way_log.delete();
    @(negedge clk);
    run_flush(cyc, acks);
    check("t5_restart_idx", 64'(rd_log[0]), 64'd0);
    check("t5_restart_reads", 64'(rd_log.size()), 64'd4);
    check("t5_restart_acks", 64'(acks), 64'd1);

    // 6: flush held for the cycle after ack
    init_mem();
    run_flush(cyc, acks);
    check("t6_single_ack", 64'(acks), 64'd1);
    check("t6_no_second_walk", 64'(rd_log.size()), 64'd4);
    check("t6_idle", 64'(bus.flush_busy_o), 64'd0);
    check("t6_no_tag_req", 64'(bus.tag_req_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
